fir_axil_cfg: RTL and testbench

AXI-Lite responder and configuration register file for the FIR engine. It answers the configuration master's AXI-Lite writes and reads, and holds the ap_ctrl and data_length registers. It owns the tap-coefficient BRAM port and hands that port to the FIR datapath while a run is in progress. It sits between the AXI-Lite bus and the FIR core plus its tap BRAM (bram11).

---
 rtl/fir_axil_cfg.sv | 211 +++++++++++++++++++++
 tb/tb_fir_axil_cfg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axil_cfg.sv
// rtl/fir_axil_cfg.sv - AXI-Lite config responder and register file for the FIR engine
//
// Holds ap_ctrl (0x00) and data_length (0x10). Taps live in an external BRAM
// at 0x20.. whose port this block owns while idle and lends to the core
// while a run is in progress.
//
// Ports:
//   axis_clk, axis_rst_n            clock, async active-low reset
//   aw*/w*                          AXI-Lite write address / data channels
//   ar*/r*                          AXI-Lite read address / data channels
//   tap_WE/EN/Di/A, tap_Do          tap BRAM port (Do valid 1 cycle after EN)
//   ap_start_o                      one-cycle start pulse to the core
//   core_done_i                     one-cycle done pulse from the core
//   core_tap_EN, core_tap_A         core tap-read request, routed while busy
//   data_length_o                   data_length register
module fir_axil_cfg #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   ap_start_o,
  input  logic                   core_done_i,
  input  logic                   core_tap_EN,
  input  logic [pADDR_WIDTH-1:0] core_tap_A,
  output logic [31:0]            data_length_o
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h20);
  localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32'h20 + 4 * (Tape_Num - 1));

  typedef enum logic {W_IDLE, W_ACK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [pADDR_WIDTH-1:0] w_addr;
  logic [pDATA_WIDTH-1:0] w_data;
  logic [pADDR_WIDTH-1:0] r_addr;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [pDATA_WIDTH-1:0] rd_value;
  logic                   ar_pend;      // arready pulse for the pending AR
  logic                   rd_busy;      // core owned the BRAM when this read was issued
  logic                   rd_clr_done;  // this read returned ap_done=1
  logic                   ap_start;
  logic                   ap_done;
  logic                   ap_idle;
  logic [31:0]            data_length;
  logic                   w_commit;
  logic                   w_tap_use;
  logic                   r_grant;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a <= TAP_LAST) && (a[1:0] == 2'b00);
  endfunction

  assign w_commit  = (w_state == W_ACK);
  // Tap writes only reach the BRAM while this block owns the port.
  assign w_tap_use = w_commit && ap_idle && is_tap(w_addr);
  // A committing tap write takes the port; the read waits in R_ADDR.
  assign r_grant   = (r_state == R_ADDR) && !w_tap_use;

  // State registers
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid && wvalid) w_next = W_ACK;
      W_ACK:   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_pend && arvalid) r_next = R_ADDR;
      R_ADDR:  if (r_grant) r_next = R_WAIT;
      R_WAIT:  r_next = R_DATA;
      R_DATA:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    awready       = w_commit;
    wready        = w_commit;
    arready       = (r_state == R_IDLE) && ar_pend;
    rvalid        = (r_state == R_DATA);
    rdata         = rdata_q;
    ap_start_o    = ap_start;
    data_length_o = data_length;
    tap_EN        = 1'b0;
    tap_WE        = 4'h0;
    tap_A         = '0;
    tap_Di        = '0;
    if (!ap_idle) begin
      tap_EN = core_tap_EN;
      tap_A  = core_tap_A;
    end else if (w_tap_use) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = w_addr - TAP_BASE;
      tap_Di = w_data;
    end else if ((r_state == R_ADDR) && is_tap(r_addr)) begin
      tap_EN = 1'b1;
      tap_A  = r_addr - TAP_BASE;
    end
  end

  always_comb begin
    rd_value = '0;
    if (r_addr == ADDR_CTRL)
      rd_value = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
    else if (r_addr == ADDR_LEN)
      rd_value = pDATA_WIDTH'(data_length);
    else if (is_tap(r_addr))
      rd_value = rd_busy ? '1 : tap_Do;
  end

  // Datapath and control registers
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      w_addr      <= '0;
      w_data      <= '0;
      r_addr      <= '0;
      rdata_q     <= '0;
      ar_pend     <= 1'b0;
      rd_busy     <= 1'b0;
      rd_clr_done <= 1'b0;
      ap_start    <= 1'b0;
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      data_length <= '0;
    end else begin
      if ((w_state == W_IDLE) && awvalid && wvalid) begin
        w_addr <= awaddr;
        w_data <= wdata;
      end

      // ap_start lives for exactly one cycle; its falling edge starts the run.
      if (ap_start) begin
        ap_start <= 1'b0;
        ap_idle  <= 1'b0;
      end else if (w_commit && (w_addr == ADDR_CTRL) && w_data[0] && ap_idle) begin
        ap_start <= 1'b1;
      end

      if (w_commit && (w_addr == ADDR_LEN))
        data_length <= 32'(w_data);

      // Done from the core outranks a clearing read on the same edge.
      if (core_done_i) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end else if ((r_state == R_DATA) && rready && rd_clr_done) begin
        ap_done <= 1'b0;
      end

      if (r_state == R_IDLE) begin
        if (ar_pend && arvalid) begin
          ar_pend <= 1'b0;
          r_addr  <= araddr;
        end else if (arvalid) begin
          ar_pend <= 1'b1;
        end
      end

      if (r_grant)
        rd_busy <= !ap_idle;

      if (r_state == R_WAIT) begin
        rdata_q     <= rd_value;
        rd_clr_done <= (r_addr == ADDR_CTRL) && ap_done;
      end
    end
  end

endmodule

// File: tb/tb_fir_axil_cfg.sv
// tb/tb_fir_axil_cfg.sv - self-checking bench for fir_axil_cfg
module tb_fir_axil_cfg;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, rvalid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic        ap_start_o;
  logic        core_done_i = 1'b0;
  logic        core_tap_EN = 1'b0;
  logic [11:0] core_tap_A = '0;
  logic [31:0] data_length_o;

  fir_axil_cfg #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .ap_start_o(ap_start_o), .core_done_i(core_done_i),
    .core_tap_EN(core_tap_EN), .core_tap_A(core_tap_A),
    .data_length_o(data_length_o)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap BRAM: registered read, byte-enabled write.
  logic [31:0] bram [11];
  always @(posedge axis_clk) begin
    if (tap_EN && (tap_A[5:2] < 4'd11)) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) bram[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= bram[tap_A[5:2]];
    end
  end

  int cyc = 0;
  int start_pulses = 0;
  always @(posedge axis_clk) begin
    cyc <= cyc + 1;
    if (ap_start_o) start_pulses <= start_pulses + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model of the register file.
  logic        m_idle = 1'b1;
  logic        m_done = 1'b0;
  logic [31:0] m_len = '0;
  logic [31:0] m_taps [11];
  int          exp_pulses = 0;
  int          coef [11];

  function automatic bit addr_is_tap(input logic [11:0] a);
    return (a >= 12'h20) && (a <= 12'h48) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    if (a == 12'h00) return {29'd0, m_idle, m_done, 1'b0};
    if (a == 12'h10) return m_len;
    if (addr_is_tap(a)) return m_idle ? m_taps[(a - 12'h20) / 4] : 32'hFFFF_FFFF;
    return 32'd0;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h00) begin
      if (d[0] && m_idle) begin
        m_idle = 1'b0;
        exp_pulses++;
      end
    end else if (a == 12'h10) begin
      m_len = d;
    end else if (addr_is_tap(a) && m_idle) begin
      m_taps[(a - 12'h20) / 4] = d;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    step();
    while (awready !== 1'b1 && n < 50) begin step(); n++; end
    check("awready_seen", 32'(awready), 32'd1);
    check("wready_with_aw", 32'(wready), 32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("awready_pulse", 32'(awready), 32'd0);
    check("wready_pulse", 32'(wready), 32'd0);
    model_write(a, d);
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold, input bit done_rhs,
                          output logic [31:0] data);
    int n = 0;
    int ar_cyc;
    araddr = a; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin step(); n++; end
    check("arready_seen", 32'(arready), 32'd1);
    ar_cyc = cyc;
    step();
    arvalid = 1'b0;
    check("arready_pulse", 32'(arready), 32'd0);
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin step(); n++; end
    check("rd_latency", 32'(cyc - ar_cyc), 32'd3);
    data = rdata;
    for (int h = 0; h < hold; h++) begin
      step();
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, data);
    end
    rready = 1'b1;
    if (done_rhs) core_done_i = 1'b1;
    step();
    rready = 1'b0;
    core_done_i = 1'b0;
    check("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input int hold, input bit done_rhs);
    logic [31:0] exp, got;
    exp = exp_read(a);
    axi_read(a, hold, done_rhs, got);
    check(tag, got, exp);
    if (a == 12'h00 && exp[1] && !done_rhs) m_done = 1'b0;
    if (done_rhs) begin m_done = 1'b1; m_idle = 1'b1; end
  endtask

  task automatic pulse_done();
    core_done_i = 1'b1;
    step();
    core_done_i = 1'b0;
    m_done = 1'b1;
    m_idle = 1'b1;
  endtask

  initial begin
    int n;
    int idx;
    logic [31:0] v;
    coef = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < 11; i++) begin bram[i] = '0; m_taps[i] = '0; end

    #2 axis_rst_n = 1'b0;
    step(); step();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_start", 32'(ap_start_o), 32'd0);
    check("rst_tap_en", 32'(tap_EN), 32'd0);
    check("rst_len", data_length_o, 32'd0);
    axis_rst_n = 1'b1;
    step();

    rd_check("ctrl_after_reset", 12'h00, 0, 0);
    rd_check("len_after_reset", 12'h10, 0, 0);

    // Randomized round: data_length and all taps, read back in random order.
    v = $urandom;
    wr(12'h10, v);
    rd_check("len_random", 12'h10, $urandom_range(0, 3), 0);
    for (int i = 0; i < 11; i++) wr(12'(32'h20 + 4 * i), $urandom);
    for (int k = 0; k < 11; k++) begin
      idx = $urandom_range(0, 10);
      rd_check($sformatf("tap_rand_%0d", idx), 12'(32'h20 + 4 * idx), $urandom_range(0, 3), 0);
    end

    // Directed coefficients.
    wr(12'h10, 32'd600);
    check("len_port", data_length_o, 32'd600);
    for (int i = 0; i < 11; i++) wr(12'(32'h20 + 4 * i), 32'(coef[i]));
    for (int i = 0; i < 11; i++) rd_check($sformatf("tap_%0d", i), 12'(32'h20 + 4 * i), 0, 0);

    // Unmapped addresses.
    wr(12'h0C, $urandom);
    rd_check("unmapped_0c", 12'h0C, 0, 0);
    rd_check("unmapped_04", 12'h04, 0, 0);
    rd_check("unmapped_4c", 12'h4C, 0, 0);
    rd_check("len_untouched", 12'h10, 0, 0);

    // Start a run.
    wr(12'h00, 32'd1);
    check("start_pulse_hi", 32'(ap_start_o), 32'd1);
    step();
    check("start_pulse_lo", 32'(ap_start_o), 32'd0);
    rd_check("ctrl_busy", 12'h00, 0, 0);
    wr(12'h20, 32'd99);
    core_tap_EN = 1'b1; core_tap_A = 12'h28;
    #1;
    check("core_tap_a", 32'(tap_A), 32'h28);
    check("core_tap_we", 32'(tap_WE), 32'd0);
    check("core_tap_en", 32'(tap_EN), 32'd1);
    rd_check("tap_read_busy", 12'h24, 0, 0);
    core_tap_EN = 1'b0;
    wr(12'h10, 32'd1234);
    rd_check("len_busy", 12'h10, 0, 0);
    wr(12'h00, 32'd1);
    step(); step();
    check("no_pulse_busy", 32'(start_pulses), 32'(exp_pulses));

    pulse_done();
    rd_check("ctrl_done", 12'h00, 0, 0);
    rd_check("ctrl_done_clr", 12'h00, 0, 0);
    rd_check("tap_write_dropped", 12'h20, 0, 0);

    // Done pulse coinciding with the clearing read's R handshake.
    wr(12'h00, 32'd1);
    check("start2_pulse", 32'(ap_start_o), 32'd1);
    step();
    pulse_done();
    rd_check("ctrl_done_race", 12'h00, 0, 1);
    rd_check("ctrl_done_kept", 12'h00, 0, 0);
    rd_check("ctrl_done_clr2", 12'h00, 0, 0);

    rd_check("len_hold5", 12'h10, 5, 0);

    // Reset in the middle of a read while a run is in progress.
    wr(12'h00, 32'd1);
    step();
    araddr = 12'h10; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin step(); n++; end
    step();
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin step(); n++; end
    check("rvalid_before_reset", 32'(rvalid), 32'd1);
    step();
    #1 axis_rst_n = 1'b0;
    #1;
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_arready", 32'(arready), 32'd0);
    check("reset_len", data_length_o, 32'd0);
    step();
    axis_rst_n = 1'b1;
    step();
    m_idle = 1'b1; m_done = 1'b0; m_len = '0;
    rd_check("ctrl_after_midreset", 12'h00, 0, 0);
    rd_check("len_after_midreset", 12'h10, 0, 0);
    rd_check("tap_kept_reset", 12'h28, 0, 0);
    check("start_pulse_count", 32'(start_pulses), 32'(exp_pulses));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
